// File: rtl/memory_mp.sv
// Unified instruction/data memory: NRD combinational read ports, a CPU write port and a queued IO write port.
module memory_mp #(
   parameter int DW     = 16,
   parameter int AW     = 16,
   parameter int DEPTH  = 200,
   parameter int NRD    = 3,
   parameter int QDEPTH = 4,
   parameter int CNTW   = 8
`ifdef MEMORY_MP_INIT_FILE_EN
   ,
   parameter string INIT_FILE = "prog.hex"
`endif
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic [NRD*AW-1:0]          RADDR,
   output logic [NRD*DW-1:0]          RDATA,
   input  logic                       CPU_WE,
   input  logic [AW-1:0]              CPU_WADDR,
   input  logic [DW-1:0]              CPU_WDATA,
   input  logic                       IO_WVALID,
   output logic                       IO_WREADY,
   input  logic [AW-1:0]              IO_WADDR,
   input  logic [DW-1:0]              IO_WDATA,
   output logic [$clog2(QDEPTH):0]    IO_PEND,
   output logic                       OOR_ERR,
   output logic [CNTW-1:0]            STALL_CNT
);

   localparam int PW  = $clog2(QDEPTH);
   localparam int CW  = PW + 1;
   localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0]   DEPTH_A = AW'(DEPTH);
   localparam logic [CW-1:0]   FULL_C  = CW'(QDEPTH);
   localparam logic [CNTW-1:0] SAT_C   = '1;

   logic [DW-1:0] mem [DEPTH];

   logic [AW-1:0] q_addr [QDEPTH];
   logic [DW-1:0] q_data [QDEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   logic          push;
   logic          pop;
   logic [AW-1:0] head_addr;
   logic [DW-1:0] head_data;
   logic          cpu_in_range;
   logic          head_in_range;
   logic [AW-1:0] ra;

   initial begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
   end

   assign IO_WREADY     = (count != FULL_C);
   assign IO_PEND       = count;
   assign push          = IO_WVALID && IO_WREADY;
   // the queue only drains on cycles the CPU port is idle, so the two never collide
   assign pop           = (count != '0) && !CPU_WE;
   assign head_addr     = q_addr[head];
   assign head_data     = q_data[head];
   assign cpu_in_range  = (CPU_WADDR < DEPTH_A);
   assign head_in_range = (head_addr < DEPTH_A);

   always_comb begin
      RDATA = '0;
      ra    = '0;
      for (int unsigned k = 0; k < NRD; k++) begin
         ra = RADDR[k*AW +: AW];
         if (ra < DEPTH_A) RDATA[k*DW +: DW] = mem[ra[MAW-1:0]];
      end
   end

   always_ff @(posedge CLK) begin
      if (CPU_WE && cpu_in_range)
         mem[CPU_WADDR[MAW-1:0]] <= CPU_WDATA;
      else if (pop && head_in_range)
         mem[head_addr[MAW-1:0]] <= head_data;
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         q_addr[tail] <= IO_WADDR;
         q_data[tail] <= IO_WDATA;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         OOR_ERR   <= 1'b0;
         STALL_CNT <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if ((CPU_WE && !cpu_in_range) || (pop && !head_in_range))
            OOR_ERR <= 1'b1;
         if ((count != '0) && CPU_WE && (STALL_CNT != SAT_C))
            STALL_CNT <= STALL_CNT + 1'b1;
      end
   end

endmodule

// File: tb/tb_memory_mp.sv
// Directed self-checking bench for memory_mp: reset, CPU/IO writes, queue back-pressure, ordering, OOR, async reset.
module tb_memory_mp;

   localparam int DW = 16;
   localparam int AW = 16;
   localparam int NRD = 3;
   localparam int QDEPTH = 4;
   localparam int CNTW = 8;

   logic                  CLK = 1'b0;
   logic                  RST_N;
   logic [NRD*AW-1:0]     RADDR;
   logic [NRD*DW-1:0]     RDATA;
   logic                  CPU_WE;
   logic [AW-1:0]         CPU_WADDR;
   logic [DW-1:0]         CPU_WDATA;
   logic                  IO_WVALID;
   logic                  IO_WREADY;
   logic [AW-1:0]         IO_WADDR;
   logic [DW-1:0]         IO_WDATA;
   logic [$clog2(QDEPTH):0] IO_PEND;
   logic                  OOR_ERR;
   logic [CNTW-1:0]       STALL_CNT;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   memory_mp #(.DW(DW), .AW(AW), .DEPTH(200), .NRD(NRD), .QDEPTH(QDEPTH), .CNTW(CNTW)) dut (
      .CLK(CLK), .RST_N(RST_N), .RADDR(RADDR), .RDATA(RDATA),
      .CPU_WE(CPU_WE), .CPU_WADDR(CPU_WADDR), .CPU_WDATA(CPU_WDATA),
      .IO_WVALID(IO_WVALID), .IO_WREADY(IO_WREADY), .IO_WADDR(IO_WADDR), .IO_WDATA(IO_WDATA),
      .IO_PEND(IO_PEND), .OOR_ERR(OOR_ERR), .STALL_CNT(STALL_CNT)
   );

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      RADDR = {a2, a1, a0};
      #1;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      CPU_WE = 1'b0; CPU_WADDR = '0; CPU_WDATA = '0;
      IO_WVALID = 1'b0; IO_WADDR = '0; IO_WDATA = '0;
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int a = 0; a < 4; a++) begin
         set_raddr(AW'(a), AW'(a), AW'(a));
         for (int k = 0; k < NRD; k++) begin
            checks++;
            if (RDATA[k*DW +: DW] !== 16'h0000) begin
               errors++;
               $display("FAIL reset_rdata port%0d addr%0d: got %h expected 0000", k, a, RDATA[k*DW +: DW]);
            end
         end
      end
      checks++;
      if (IO_PEND !== 3'd0) begin errors++; $display("FAIL reset_pend: got %0d expected 0", IO_PEND); end
      checks++;
      if (IO_WREADY !== 1'b1) begin errors++; $display("FAIL reset_wready: got %b expected 1", IO_WREADY); end
      checks++;
      if (OOR_ERR !== 1'b0) begin errors++; $display("FAIL reset_oor: got %b expected 0", OOR_ERR); end
      checks++;
      if (STALL_CNT !== 8'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", STALL_CNT); end
   endtask

   task automatic test_cpu_write();
      CPU_WE = 1'b1; CPU_WADDR = 16'd5; CPU_WDATA = 16'hA5A5;
      set_raddr(16'd0, 16'd5, 16'd0);
      checks++;
      if (RDATA[DW +: DW] !== 16'h0000) begin
         errors++; $display("FAIL cpu_write_before_edge: got %h expected 0000", RDATA[DW +: DW]);
      end
      next_cycle();
      CPU_WE = 1'b0;
      #1;
      checks++;
      if (RDATA[DW +: DW] !== 16'hA5A5) begin
         errors++; $display("FAIL cpu_write_after_edge: got %h expected a5a5", RDATA[DW +: DW]);
      end
      checks++;
      if (STALL_CNT !== 8'd0) begin errors++; $display("FAIL cpu_write_stall: got %0d expected 0", STALL_CNT); end
   endtask

   task automatic test_queue_stall();
      logic [13:0] we_t;
      logic [13:0] vl_t;
      logic [13:0] rdy_t;
      int pend_t[14];
      int idx_t[14];
      logic [DW-1:0] exp_d;
      we_t  = 14'b00_0000_0111_1110;
      vl_t  = 14'b00_0011_1111_1111;
      rdy_t = 14'b11_1111_0000_1111;
      pend_t = '{0, 1, 2, 3, 4, 4, 4, 4, 3, 3, 3, 2, 1, 0};
      idx_t  = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 5, 0, 0, 0, 0};
      set_raddr(16'd10, 16'd11, 16'd15);
      for (int c = 0; c < 14; c++) begin
         CPU_WE = we_t[c]; CPU_WADDR = 16'd50; CPU_WDATA = 16'h5050;
         IO_WVALID = vl_t[c];
         IO_WADDR = AW'(10 + idx_t[c]);
         IO_WDATA = DW'(16'h0010 + idx_t[c]);
         #1;
         checks++;
         if (IO_WREADY !== rdy_t[c]) begin
            errors++; $display("FAIL queue_wready cyc%0d: got %b expected %b", c, IO_WREADY, rdy_t[c]);
         end
         checks++;
         if (IO_PEND !== 3'(pend_t[c])) begin
            errors++; $display("FAIL queue_pend cyc%0d: got %0d expected %0d", c, IO_PEND, pend_t[c]);
         end
         if (c == 7) begin
            checks++;
            if (STALL_CNT !== 8'd6) begin errors++; $display("FAIL queue_stall_cnt: got %0d expected 6", STALL_CNT); end
         end
         if (c == 8) begin
            checks++;
            if (RDATA[0 +: DW] !== 16'h0010) begin errors++; $display("FAIL order_first_drain addr10: got %h expected 0010", RDATA[0 +: DW]); end
            checks++;
            if (RDATA[DW +: DW] !== 16'h0000) begin errors++; $display("FAIL order_second_pending addr11: got %h expected 0000", RDATA[DW +: DW]); end
         end
         next_cycle();
      end
      CPU_WE = 1'b0; IO_WVALID = 1'b0;
      for (int a = 10; a < 16; a++) begin
         set_raddr(AW'(a), 16'd50, 16'd0);
         exp_d = DW'(16'h0010 + (a - 10));
         checks++;
         if (RDATA[0 +: DW] !== exp_d) begin
            errors++; $display("FAIL queue_final addr%0d: got %h expected %h", a, RDATA[0 +: DW], exp_d);
         end
      end
      checks++;
      if (RDATA[DW +: DW] !== 16'h5050) begin errors++; $display("FAIL queue_cpu_addr50: got %h expected 5050", RDATA[DW +: DW]); end
      checks++;
      if (STALL_CNT !== 8'd6) begin errors++; $display("FAIL queue_stall_final: got %0d expected 6", STALL_CNT); end
   endtask

   task automatic test_collision();
      set_raddr(16'd20, 16'd0, 16'd0);
      CPU_WE = 1'b1; CPU_WADDR = 16'd20; CPU_WDATA = 16'h1111;
      IO_WVALID = 1'b1; IO_WADDR = 16'd20; IO_WDATA = 16'h2222;
      next_cycle();
      CPU_WE = 1'b0; IO_WVALID = 1'b0;
      #1;
      checks++;
      if (RDATA[0 +: DW] !== 16'h1111) begin errors++; $display("FAIL collision_cpu_first: got %h expected 1111", RDATA[0 +: DW]); end
      checks++;
      if (IO_PEND !== 3'd1) begin errors++; $display("FAIL collision_pend: got %0d expected 1", IO_PEND); end
      next_cycle();
      checks++;
      if (RDATA[0 +: DW] !== 16'h2222) begin errors++; $display("FAIL collision_io_wins: got %h expected 2222", RDATA[0 +: DW]); end
      checks++;
      if (IO_PEND !== 3'd0) begin errors++; $display("FAIL collision_pend_drained: got %0d expected 0", IO_PEND); end
   endtask

   task automatic test_oor_cpu();
      CPU_WE = 1'b1; CPU_WADDR = 16'd200; CPU_WDATA = 16'hFFFF;
      #1;
      checks++;
      if (OOR_ERR !== 1'b0) begin errors++; $display("FAIL oor_cpu_before: got %b expected 0", OOR_ERR); end
      next_cycle();
      CPU_WE = 1'b0;
      set_raddr(16'd250, 16'd0, 16'd199);
      checks++;
      if (OOR_ERR !== 1'b1) begin errors++; $display("FAIL oor_cpu_set: got %b expected 1", OOR_ERR); end
      checks++;
      if (RDATA[0 +: DW] !== 16'h0000) begin errors++; $display("FAIL oor_read250: got %h expected 0000", RDATA[0 +: DW]); end
      checks++;
      if (RDATA[DW +: DW] !== 16'h0000) begin errors++; $display("FAIL oor_cpu_addr0: got %h expected 0000", RDATA[DW +: DW]); end
      checks++;
      if (RDATA[2*DW +: DW] !== 16'h0000) begin errors++; $display("FAIL oor_cpu_addr199: got %h expected 0000", RDATA[2*DW +: DW]); end
      repeat (3) next_cycle();
      checks++;
      if (OOR_ERR !== 1'b1) begin errors++; $display("FAIL oor_cpu_sticky: got %b expected 1", OOR_ERR); end
   endtask

   task automatic test_oor_reset();
      do_reset();
      set_raddr(16'd5, 16'd20, 16'd50);
      checks++;
      if (OOR_ERR !== 1'b0) begin errors++; $display("FAIL oor_cleared_by_reset: got %b expected 0", OOR_ERR); end
      checks++;
      if (RDATA[0 +: DW] !== 16'hA5A5) begin errors++; $display("FAIL reset_keeps_addr5: got %h expected a5a5", RDATA[0 +: DW]); end
      checks++;
      if (RDATA[DW +: DW] !== 16'h2222) begin errors++; $display("FAIL reset_keeps_addr20: got %h expected 2222", RDATA[DW +: DW]); end
   endtask

   task automatic test_oor_io();
      IO_WVALID = 1'b1; IO_WADDR = 16'd300; IO_WDATA = 16'hFFFF;
      next_cycle();
      IO_WVALID = 1'b0;
      #1;
      checks++;
      if (IO_PEND !== 3'd1) begin errors++; $display("FAIL oor_io_accepted: got %0d expected 1", IO_PEND); end
      checks++;
      if (OOR_ERR !== 1'b0) begin errors++; $display("FAIL oor_io_not_at_accept: got %b expected 0", OOR_ERR); end
      next_cycle();
      set_raddr(16'd250, 16'd44, 16'd300);
      checks++;
      if (IO_PEND !== 3'd0) begin errors++; $display("FAIL oor_io_slot_consumed: got %0d expected 0", IO_PEND); end
      checks++;
      if (OOR_ERR !== 1'b1) begin errors++; $display("FAIL oor_io_set: got %b expected 1", OOR_ERR); end
      checks++;
      if (RDATA[0 +: DW] !== 16'h0000) begin errors++; $display("FAIL oor_io_read250: got %h expected 0000", RDATA[0 +: DW]); end
      checks++;
      if (RDATA[DW +: DW] !== 16'h0000) begin errors++; $display("FAIL oor_io_addr44: got %h expected 0000", RDATA[DW +: DW]); end
      checks++;
      if (RDATA[2*DW +: DW] !== 16'h0000) begin errors++; $display("FAIL oor_io_read300: got %h expected 0000", RDATA[2*DW +: DW]); end
      repeat (3) next_cycle();
      checks++;
      if (OOR_ERR !== 1'b1) begin errors++; $display("FAIL oor_io_sticky: got %b expected 1", OOR_ERR); end
   endtask

   task automatic test_reset_mid();
      set_raddr(16'd30, 16'd31, 16'd32);
      for (int i = 0; i < 3; i++) begin
         CPU_WE = 1'b1; CPU_WADDR = 16'd60; CPU_WDATA = 16'h6060;
         IO_WVALID = 1'b1; IO_WADDR = AW'(30 + i); IO_WDATA = DW'(16'h0300 + i);
         next_cycle();
      end
      IO_WVALID = 1'b0;
      #1;
      checks++;
      if (IO_PEND !== 3'd3) begin errors++; $display("FAIL mid_pend_before: got %0d expected 3", IO_PEND); end
      checks++;
      if (STALL_CNT !== 8'd2) begin errors++; $display("FAIL mid_stall_before: got %0d expected 2", STALL_CNT); end
      #1;
      RST_N = 1'b0; CPU_WE = 1'b0;
      #1;
      checks++;
      if (IO_PEND !== 3'd0) begin errors++; $display("FAIL mid_pend_async: got %0d expected 0", IO_PEND); end
      checks++;
      if (IO_WREADY !== 1'b1) begin errors++; $display("FAIL mid_wready_async: got %b expected 1", IO_WREADY); end
      checks++;
      if (STALL_CNT !== 8'd0) begin errors++; $display("FAIL mid_stall_async: got %0d expected 0", STALL_CNT); end
      checks++;
      if (OOR_ERR !== 1'b0) begin errors++; $display("FAIL mid_oor_async: got %b expected 0", OOR_ERR); end
      next_cycle();
      RST_N = 1'b1;
      repeat (5) next_cycle();
      for (int k = 0; k < NRD; k++) begin
         checks++;
         if (RDATA[k*DW +: DW] !== 16'h0000) begin
            errors++; $display("FAIL mid_discarded addr%0d: got %h expected 0000", 30 + k, RDATA[k*DW +: DW]);
         end
      end
      set_raddr(16'd60, 16'd0, 16'd0);
      checks++;
      if (RDATA[0 +: DW] !== 16'h6060) begin errors++; $display("FAIL mid_cpu_addr60: got %h expected 6060", RDATA[0 +: DW]); end
   endtask

   initial begin
      RADDR = '0;
      test_reset();
      test_cpu_write();
      test_queue_stall();
      test_collision();
      test_oor_cpu();
      test_oor_reset();
      test_oor_io();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
